// File: rtl/uart_tx_regfile_if.sv
// rtl/uart_tx_regfile_if.sv - 4x8 register bus between host and UART transmit register file
//  wBus       write data, stable while a strobe is high
//  we0..we3   level write strobes for TXDATA, STATUS, CTRL, BAUDDIV (asynchronous to clk)
//  rBus0..3   register read values
interface uart_tx_regfile_if;
    logic [7:0] wBus;
    logic       we0;
    logic       we1;
    logic       we2;
    logic       we3;
    logic [7:0] rBus0;
    logic [7:0] rBus1;
    logic [7:0] rBus2;
    logic [7:0] rBus3;

    modport master (
        output wBus, we0, we1, we2, we3,
        input  rBus0, rBus1, rBus2, rBus3
    );

    modport slave (
        input  wBus, we0, we1, we2, we3,
        output rBus0, rBus1, rBus2, rBus3
    );
endinterface

// File: rtl/uart_tx_regfile.sv
// rtl/uart_tx_regfile.sv - UART register file, TX FIFO and serial transmit engine
//  clk    system clock, rising edge
//  rst_n  asynchronous active-low reset
//  bus    register bus (slave side): strobes in, read values out
//  txd    serial output, idle high
//  irq    level interrupt: irq_en & empty & ~busy
module uart_tx_regfile #(
    parameter int         FIFO_DEPTH    = 4,
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] RESET_BAUDDIV = 8'd103
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_regfile_if.slave    bus,
    output logic                txd,
    output logic                irq
);
    localparam int         PW     = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH4 = 4'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0]    we_prev_q, we_prev_d;
    logic [3:0]    commit;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [7:0]    bauddiv_q, bauddiv_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    state_t        state_q, state_d;
    logic [7:0]    baud_cnt_q, baud_cnt_d;
    logic [7:0]    div_q, div_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;
    logic          pop, push_ok, tick;

    always_comb begin
        // Strobe synchroniser; a commit is the rising edge of the synced level.
        sync_d    = {sync_q[SYNC_STAGES-2:0], {bus.we3, bus.we2, bus.we1, bus.we0}};
        we_prev_d = sync_q[SYNC_STAGES-1];
        commit    = sync_q[SYNC_STAGES-1] & ~we_prev_q;

        // The engine only pops from IDLE, so a push into an empty FIFO is never popped the same cycle.
        pop     = (state_q == IDLE) && ctrl_q[0] && (count_q != 4'd0);
        push_ok = commit[0] && ((count_q != DEPTH4) || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.wBus;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + {3'b000, push_ok} - {3'b000, pop};

        ovf_d = ovf_q;
        if (commit[1] && bus.wBus[3]) ovf_d = 1'b0;
        if (commit[0] && !push_ok)    ovf_d = 1'b1;

        ctrl_d    = commit[2] ? bus.wBus[3:0] : ctrl_q;
        bauddiv_d = commit[3] ? bus.wBus : bauddiv_q;

        // Transmit engine; divider and parity settings are latched per frame.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 8'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tick       = (baud_cnt_q == div_q);
        case (state_q)
            IDLE: begin
                baud_cnt_d = 8'd0;
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    div_d     = bauddiv_q;
                    par_en_d  = ctrl_q[1];
                    par_bit_d = (^mem_q[rd_ptr_q]) ^ ctrl_q[2];
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    baud_cnt_d = 8'd0;
                    bit_cnt_d  = 3'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    baud_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    baud_cnt_d = 8'd0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    baud_cnt_d = 8'd0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with the state flops.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_bit_d;
            default: txd_d = 1'b1;
        endcase
        irq_d = ctrl_d[3] && (count_d == 4'd0) && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            we_prev_q  <= 4'd0;
            ctrl_q     <= 4'd0;
            bauddiv_q  <= RESET_BAUDDIV;
            ovf_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            state_q    <= IDLE;
            baud_cnt_q <= 8'd0;
            div_q      <= 8'd0;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            txd_q      <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            we_prev_q  <= we_prev_d;
            ctrl_q     <= ctrl_d;
            bauddiv_q  <= bauddiv_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.rBus0 = 8'h00;
    assign bus.rBus1 = {count_q, ovf_q, (state_q != IDLE), (count_q == DEPTH4), (count_q == 4'd0)};
    assign bus.rBus2 = {4'b0000, ctrl_q};
    assign bus.rBus3 = bauddiv_q;
    assign txd       = txd_q;
    assign irq       = irq_q;
endmodule
